vx_cache_flush_ctrl: RTL and testbench
======================================

Name: VX_cache_flush_ctrl

Overview:
Sequences a full-cache flush/invalidate for the VX cache wrapper.
- On a flush request it locks new core requests and waits for in-flight core requests to drain.
- It then walks every set/way, broadcasting a flush-line command to all banks, and waits for all banks to go idle (writebacks retired).
- It then returns a flush response carrying the requester's tag.
- Sits between the core-side request gating and the per-bank flush ports of the cache.

Parameters:
- NUM_REQS, 4, core request ports monitored for outstanding traffic
- NUM_BANKS, 4, cache banks receiving flush-line commands
- NUM_WAYS, 4, associative ways per set
- CACHE_SIZE, 65536, cache size in bytes
- LINE_SIZE, 64, line size in bytes
- MAX_PENDING, 64, maximum outstanding core requests tracked (counter depth)
- TAG_WIDTH, 16, flush request/response tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush_req_valid  in  1  flush request
- flush_req_tag  in  TAG_WIDTH  tag returned on completion
- flush_req_ready  out  1  flush request accepted
- flush_rsp_valid  out  1  flush complete
- flush_rsp_tag  out  TAG_WIDTH  tag of completed flush
- flush_rsp_ready  in  1  response consumed
- core_req_fire  in  NUM_REQS  per-port core request handshake this cycle
- core_rsp_fire  in  NUM_REQS  per-port core response handshake this cycle
- core_req_lock  out  1  gate: when high, wrapper forces core_req_ready low
- flush_line_valid  out  NUM_BANKS  per-bank flush-line command valid
- flush_line_set  out  SET_BITS  set index being flushed
- flush_line_way  out  WAY_BITS  way index being flushed
- flush_line_ready  in  NUM_BANKS  per-bank command accept
- bank_idle  in  NUM_BANKS  bank has no pending MSHR/writeback work
- busy  out  1  state != IDLE

Behaviour:
- Derived constants:
  - NUM_SETS = CACHE_SIZE / (LINE_SIZE*NUM_BANKS*NUM_WAYS)
  - SET_BITS = max(1, clog2(NUM_SETS))
  - WAY_BITS = max(1, clog2(NUM_WAYS))
- Reset values:
  - state = IDLE
  - all outputs 0
  - pending counter 0, set/way counters 0, bank-accepted mask 0
- Pending counter (clog2(MAX_PENDING+1) bits), updated every cycle in every state:
  - pending += popcount(core_req_fire) - popcount(core_rsp_fire)
  - req and rsp in the same cycle net out
  - Underflow saturates at 0 and fires a runtime assertion.
  - Exceeding MAX_PENDING fires an assertion.
- States:
  - IDLE: flush_req_ready=1. On flush_req_valid, latch tag, go to DRAIN. Acceptance is the cycle valid&&ready.
  - DRAIN: core_req_lock=1. core_req_fire arriving in the first DRAIN cycle (lock latency 1) is still counted. Leave for WALK when pending==0 and no core_req_fire this cycle.
  - WALK: core_req_lock=1.
    - flush_line_valid[b] = ~accepted[b].
    - accepted[b] is set on valid[b]&&ready[b]; banks may accept in different cycles.
    - When (accepted | fire) is all ones: clear the mask and advance way. On way wrap (NUM_WAYS-1 -> 0), advance set.
    - After set NUM_SETS-1 / way NUM_WAYS-1 is accepted, go to WAIT.
    - Each command is held stable until accepted.
  - WAIT: core_req_lock=1. Go to DONE on the first cycle with &bank_idle. bank_idle is sampled at least one cycle after the last command accept.
  - DONE: core_req_lock=1, flush_rsp_valid=1 with the latched tag. On flush_rsp_ready go to IDLE; lock drops the next cycle.
- flush_req_ready=0 outside IDLE, so back-to-back flushes serialize. A new request is accepted in the cycle after returning to IDLE.
- Walk length is exactly NUM_SETS*NUM_WAYS commands per bank. Minimum WALK duration is NUM_SETS*NUM_WAYS cycles when all banks are always ready.
- Reset mid-operation: immediately returns to IDLE; the latched flush is abandoned with no response.
- core_req_lock is registered; it rises the cycle after flush acceptance.

Decomposition:
- Shared in VX_gpu_pkg: flush state enum (IDLE/DRAIN/WALK/WAIT/DONE) and the NUM_SETS helper function (reused by the bank tag store).
- One natural sub-module: VX_pending_size-style popcount up/down counter, VX_flush_pending_cnt (NUM_REQS ports, MAX_PENDING depth).
- FSM and walk counters stay in the top.

Test Plan:
Use CACHE_SIZE=1024, LINE_SIZE=64, NUM_BANKS=2, NUM_WAYS=2 (NUM_SETS=4).
1. Idle flush: pending=0, bank_idle=11, ready=11, flush_req tag=0x5A.
   - 8 commands: (set,way) = (0,0),(0,1),(1,0)...(3,1).
   - flush_rsp_valid with tag 0x5A; core_req_lock high from acceptance+1 until rsp handshake.
2. Drain: 3 requests outstanding, flush accepted.
   - Stays in DRAIN with no flush_line_valid until the 3rd core_rsp_fire; WALK starts the next cycle.
   - A core_req_fire in the first DRAIN cycle extends the drain by one response.
3. Skewed banks: bank0 ready always, bank1 ready every 3rd cycle.
   - Bank0 valid drops after its accept and waits for bank1.
   - Every (set,way) is seen exactly once per bank; 8 accepts per bank.
4. Writeback wait: bank_idle=01 for 10 cycles after the last accept.
   - flush_rsp_valid stays 0 and asserts the first cycle after bank_idle=11.
5. Backpressure/serialize: flush_rsp_ready low 5 cycles while a second flush_req_valid is held.
   - Response held stable; second flush accepted only after the first response handshake.
6. Reset in WALK at set 2: outputs all 0 the next cycle, busy=0.
   - A new flush walks again from (0,0).

Source files
------------

// File: rtl/vx_cache_flush_ctrl_pkg.sv
// Shared flush-controller types and geometry helpers for the VX cache.
// The set-count helper is also used by the bank tag store.
package vx_cache_flush_ctrl_pkg;

    typedef enum logic [2:0] {
        FLUSH_IDLE  = 3'd0,
        FLUSH_DRAIN = 3'd1,
        FLUSH_WALK  = 3'd2,
        FLUSH_WAIT  = 3'd3,
        FLUSH_DONE  = 3'd4
    } flush_state_e;

    function automatic int numSets(input int cacheSize, input int lineSize,
                                   input int numBanks, input int numWays);
        return cacheSize / (lineSize * numBanks * numWays);
    endfunction

    // Index width that never collapses to zero bits for degenerate geometries.
    function automatic int bitsMin1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/vx_cache_flush_ctrl_pending_cnt.sv
// Up/down counter of outstanding core requests: adds the popcount of request
// handshakes and subtracts the popcount of response handshakes each cycle.
module vx_flush_pending_cnt #(
    parameter  int NUM_REQS    = 4,
    parameter  int MAX_PENDING = 64,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] i_reqFire,
    input  logic [NUM_REQS-1:0] i_rspFire,
    output logic [CNT_W-1:0]    o_countNext
);

    localparam int POP_W = $clog2(NUM_REQS + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    logic [CNT_W-1:0] r_count;
    logic [SUM_W-1:0] w_incCnt;
    logic [SUM_W-1:0] w_decCnt;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_diff;
    logic             w_underflow;
    logic             w_overflow;

    // One extra bit of headroom so both the underflow and overflow cases are visible.
    always_comb begin
        w_incCnt = '0;
        w_decCnt = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_incCnt = w_incCnt + SUM_W'(i_reqFire[i]);
            w_decCnt = w_decCnt + SUM_W'(i_rspFire[i]);
        end
        w_sum       = SUM_W'(r_count) + w_incCnt;
        w_underflow = (w_sum < w_decCnt);
        w_diff      = w_sum - w_decCnt;
        w_overflow  = !w_underflow && (w_diff > SUM_W'(MAX_PENDING));
        if (w_underflow) begin
            o_countNext = '0;
        end else if (w_overflow) begin
            o_countNext = CNT_W'(MAX_PENDING);
        end else begin
            o_countNext = w_diff[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= o_countNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!w_underflow) else $error("pending counter underflow");
            assert (!w_overflow) else $error("pending counter exceeded MAX_PENDING");
        end
    end

endmodule

// File: rtl/vx_cache_flush_ctrl.sv
// Full-cache flush sequencer: locks core requests, drains in-flight traffic,
// walks every set/way across all banks, waits for writebacks, then responds.
module vx_cache_flush_ctrl
    import vx_cache_flush_ctrl_pkg::*;
#(
    parameter  int NUM_REQS    = 4,
    parameter  int NUM_BANKS   = 4,
    parameter  int NUM_WAYS    = 4,
    parameter  int CACHE_SIZE  = 65536,
    parameter  int LINE_SIZE   = 64,
    parameter  int MAX_PENDING = 64,
    parameter  int TAG_WIDTH   = 16,
    localparam int NUM_SETS    = numSets(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS),
    localparam int SET_BITS    = bitsMin1(NUM_SETS),
    localparam int WAY_BITS    = bitsMin1(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_req_valid,
    input  logic [TAG_WIDTH-1:0] flush_req_tag,
    output logic                 flush_req_ready,
    output logic                 flush_rsp_valid,
    output logic [TAG_WIDTH-1:0] flush_rsp_tag,
    input  logic                 flush_rsp_ready,
    input  logic [NUM_REQS-1:0]  core_req_fire,
    input  logic [NUM_REQS-1:0]  core_rsp_fire,
    output logic                 core_req_lock,
    output logic [NUM_BANKS-1:0] flush_line_valid,
    output logic [SET_BITS-1:0]  flush_line_set,
    output logic [WAY_BITS-1:0]  flush_line_way,
    input  logic [NUM_BANKS-1:0] flush_line_ready,
    input  logic [NUM_BANKS-1:0] bank_idle,
    output logic                 busy
);

    localparam int                  CNT_W    = $clog2(MAX_PENDING + 1);
    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);
    localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(NUM_WAYS - 1);

    flush_state_e         r_state;
    flush_state_e         w_stateNext;
    logic [NUM_BANKS-1:0] r_accepted;
    logic [NUM_BANKS-1:0] w_acceptedNext;
    logic [NUM_BANKS-1:0] w_acceptedNow;
    logic [NUM_BANKS-1:0] w_lineValid;
    logic [SET_BITS-1:0]  r_set;
    logic [SET_BITS-1:0]  w_setNext;
    logic [WAY_BITS-1:0]  r_way;
    logic [WAY_BITS-1:0]  w_wayNext;
    logic [TAG_WIDTH-1:0] r_tag;
    logic                 r_lock;
    logic [CNT_W-1:0]     w_pendingNext;

    vx_flush_pending_cnt #(
        .NUM_REQS    (NUM_REQS),
        .MAX_PENDING (MAX_PENDING)
    ) u_pendingCnt (
        .clk         (clk),
        .reset       (reset),
        .i_reqFire   (core_req_fire),
        .i_rspFire   (core_rsp_fire),
        .o_countNext (w_pendingNext)
    );

    // A bank keeps its command valid until it accepts; the line only advances
    // once every bank has taken the current (set, way).
    assign w_lineValid   = (r_state == FLUSH_WALK) ? ~r_accepted : '0;
    assign w_acceptedNow = r_accepted | (w_lineValid & flush_line_ready);

    always_comb begin
        w_stateNext    = r_state;
        w_acceptedNext = r_accepted;
        w_setNext      = r_set;
        w_wayNext      = r_way;
        case (r_state)
            FLUSH_IDLE: begin
                if (flush_req_valid) w_stateNext = FLUSH_DRAIN;
            end
            FLUSH_DRAIN: begin
                if ((w_pendingNext == '0) && !(|core_req_fire)) w_stateNext = FLUSH_WALK;
            end
            FLUSH_WALK: begin
                if (&w_acceptedNow) begin
                    w_acceptedNext = '0;
                    if (r_way == LAST_WAY) begin
                        w_wayNext = '0;
                        if (r_set == LAST_SET) begin
                            w_setNext   = '0;
                            w_stateNext = FLUSH_WAIT;
                        end else begin
                            w_setNext = r_set + 1'b1;
                        end
                    end else begin
                        w_wayNext = r_way + 1'b1;
                    end
                end else begin
                    w_acceptedNext = w_acceptedNow;
                end
            end
            FLUSH_WAIT: begin
                if (&bank_idle) w_stateNext = FLUSH_DONE;
            end
            FLUSH_DONE: begin
                if (flush_rsp_ready) w_stateNext = FLUSH_IDLE;
            end
            default: w_stateNext = FLUSH_IDLE;
        endcase
    end

    // Lock is registered from the next state so it rises the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FLUSH_IDLE;
            r_accepted <= '0;
            r_set      <= '0;
            r_way      <= '0;
            r_tag      <= '0;
            r_lock     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_accepted <= w_acceptedNext;
            r_set      <= w_setNext;
            r_way      <= w_wayNext;
            r_lock     <= (w_stateNext != FLUSH_IDLE);
            if ((r_state == FLUSH_IDLE) && flush_req_valid) r_tag <= flush_req_tag;
        end
    end

    assign flush_req_ready  = (r_state == FLUSH_IDLE) && !reset;
    assign flush_rsp_valid  = (r_state == FLUSH_DONE);
    assign flush_rsp_tag    = flush_rsp_valid ? r_tag : '0;
    assign core_req_lock    = r_lock;
    assign flush_line_valid = w_lineValid;
    assign flush_line_set   = r_set;
    assign flush_line_way   = r_way;
    assign busy             = (r_state != FLUSH_IDLE);

endmodule

// File: tb/tb_vx_cache_flush_ctrl.sv
// Self-checking bench for vx_cache_flush_ctrl on a 4-set, 2-way, 2-bank geometry.
// Flush scenarios come from a vector table; commands and tags go through scoreboards.
module tb_vx_cache_flush_ctrl;

    localparam int TAG_W   = 16;
    localparam int BUDGET  = 200;

    typedef struct {
        logic [TAG_W-1:0] tag;
        int preReqs;
        int extraReq;
        int rspGap;
        int b1Period;
        int wbCycles;
        int rspStall;
        int holdNext;
        int expFirstValid;
        int expWalk;
        int expWait;
        int expCmds;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             flush_req_valid;
    logic [TAG_W-1:0] flush_req_tag;
    logic             flush_req_ready;
    logic             flush_rsp_valid;
    logic [TAG_W-1:0] flush_rsp_tag;
    logic             flush_rsp_ready;
    logic [1:0]       core_req_fire;
    logic [1:0]       core_rsp_fire;
    logic             core_req_lock;
    logic [1:0]       flush_line_valid;
    logic [1:0]       flush_line_set;
    logic [0:0]       flush_line_way;
    logic [1:0]       flush_line_ready;
    logic [1:0]       bank_idle;
    logic             busy;

    int compared;
    int mismatched;

    vec_t             vecs[8];
    logic [2:0]       cmdQ[2][$];
    logic [TAG_W-1:0] tagQ[$];

    vx_cache_flush_ctrl #(
        .NUM_REQS    (2),
        .NUM_BANKS   (2),
        .NUM_WAYS    (2),
        .CACHE_SIZE  (1024),
        .LINE_SIZE   (64),
        .MAX_PENDING (16),
        .TAG_WIDTH   (TAG_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flush_req_valid  (flush_req_valid),
        .flush_req_tag    (flush_req_tag),
        .flush_req_ready  (flush_req_ready),
        .flush_rsp_valid  (flush_rsp_valid),
        .flush_rsp_tag    (flush_rsp_tag),
        .flush_rsp_ready  (flush_rsp_ready),
        .core_req_fire    (core_req_fire),
        .core_rsp_fire    (core_rsp_fire),
        .core_req_lock    (core_req_lock),
        .flush_line_valid (flush_line_valid),
        .flush_line_set   (flush_line_set),
        .flush_line_way   (flush_line_way),
        .flush_line_ready (flush_line_ready),
        .bank_idle        (bank_idle),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_req_ready"}, 32'(flush_req_ready), 0);
        checkOutput({pfx, "_rsp_valid"}, 32'(flush_rsp_valid), 0);
        checkOutput({pfx, "_rsp_tag"}, 32'(flush_rsp_tag), 0);
        checkOutput({pfx, "_lock"}, 32'(core_req_lock), 0);
        checkOutput({pfx, "_line_valid"}, 32'(flush_line_valid), 0);
        checkOutput({pfx, "_line_set"}, 32'(flush_line_set), 0);
        checkOutput({pfx, "_line_way"}, 32'(flush_line_way), 0);
        checkOutput({pfx, "_busy"}, 32'(busy), 0);
    endtask

    // Runs one full flush: optional pre-load of outstanding requests, acceptance,
    // drain, walk with bank backpressure, writeback wait and response handshake.
    task automatic applyStimulus(input int idx, input vec_t v, input logic [TAG_W-1:0] nextTag);
        int         rem;
        int         k;
        int         rspsLeft;
        int         firstValid;
        int         walkCycles;
        int         waitCnt;
        int         acc[2];
        int         wbLeft;
        int         stallLeft;
        bit         walkDone;
        bit         rspSeen;
        bit         gotRsp;
        logic [1:0] prevHeld;
        logic [2:0] prevCmd;
        logic [2:0] cmd;
        logic [2:0] exp;
        string      p;

        p = $sformatf("v%0d", idx);
        rem = v.preReqs;
        while (rem > 0) begin
            @(posedge clk); #1;
            flush_req_valid = 1'b0;
            core_rsp_fire   = '0;
            core_req_fire   = (rem >= 2) ? 2'b11 : 2'b01;
            rem -= (rem >= 2) ? 2 : 1;
        end

        @(posedge clk); #1;
        core_req_fire    = '0;
        core_rsp_fire    = '0;
        flush_req_valid  = 1'b1;
        flush_req_tag    = v.tag;
        flush_line_ready = 2'b00;
        bank_idle        = (v.wbCycles > 0) ? 2'b01 : 2'b11;
        flush_rsp_ready  = 1'b0;
        @(negedge clk);
        checkOutput({p, "_accept_ready"}, 32'(flush_req_ready), 1);
        checkOutput({p, "_accept_lock"}, 32'(core_req_lock), 0);
        checkOutput({p, "_accept_busy"}, 32'(busy), 0);
        tagQ.push_back(v.tag);
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                cmd = 3'(s * 2 + w);
                cmdQ[0].push_back(cmd);
                cmdQ[1].push_back(cmd);
            end
        end

        k = 0; rspsLeft = v.preReqs + v.extraReq; firstValid = -1; walkCycles = 0;
        waitCnt = 0; acc[0] = 0; acc[1] = 0; wbLeft = 0; stallLeft = v.rspStall;
        walkDone = 0; rspSeen = 0; gotRsp = 0; prevHeld = '0; prevCmd = '0;
        while (!gotRsp && k < BUDGET) begin
            k++;
            @(posedge clk); #1;
            flush_req_valid  = (v.holdNext != 0);
            flush_req_tag    = (v.holdNext != 0) ? nextTag : v.tag;
            core_req_fire    = (v.extraReq != 0 && k == 1) ? 2'b10 : 2'b00;
            core_rsp_fire    = '0;
            if (rspsLeft > 0 && (k % v.rspGap) == 0) begin
                core_rsp_fire = (rspsLeft % 2 != 0) ? 2'b01 : 2'b10;
                rspsLeft--;
            end
            flush_line_ready = {(v.b1Period <= 1) || ((k % v.b1Period) == 0), 1'b1};
            if (walkDone) begin
                bank_idle = (wbLeft > 0) ? 2'b01 : 2'b11;
                if (wbLeft > 0) wbLeft--;
            end else begin
                bank_idle = (v.wbCycles > 0) ? 2'b01 : 2'b11;
            end
            flush_rsp_ready = (stallLeft == 0);

            @(negedge clk);
            checkOutput({p, "_busy"}, 32'(busy), 1);
            checkOutput({p, "_lock"}, 32'(core_req_lock), 1);
            checkOutput({p, "_req_ready_low"}, 32'(flush_req_ready), 0);
            if (firstValid < 0 && |flush_line_valid) firstValid = k;
            if (|flush_line_valid) walkCycles++;
            cmd = {flush_line_set, flush_line_way};
            for (int b = 0; b < 2; b++) begin
                if (prevHeld[b]) begin
                    checkOutput($sformatf("%s_hold_valid_b%0d", p, b), 32'(flush_line_valid[b]), 1);
                    checkOutput($sformatf("%s_hold_cmd_b%0d", p, b), 32'(cmd), 32'(prevCmd));
                end
                if (flush_line_valid[b] && flush_line_ready[b]) begin
                    if (cmdQ[b].size() == 0) begin
                        checkOutput($sformatf("%s_extra_accept_b%0d", p, b), 32'(acc[b] + 1), 32'(v.expCmds));
                    end else begin
                        exp = cmdQ[b].pop_front();
                        checkOutput($sformatf("%s_cmd_b%0d", p, b), 32'(cmd), 32'(exp));
                    end
                    acc[b]++;
                end
            end
            prevHeld = flush_line_valid & ~flush_line_ready;
            prevCmd  = cmd;

            if (!walkDone && acc[0] == v.expCmds && acc[1] == v.expCmds) begin
                walkDone = 1;
                waitCnt  = 0;
                wbLeft   = v.wbCycles;
            end else if (walkDone && !rspSeen) begin
                waitCnt++;
            end

            if (rspSeen) checkOutput({p, "_rsp_held"}, 32'(flush_rsp_valid), 1);
            if (flush_rsp_valid) begin
                if (!rspSeen) begin
                    rspSeen = 1;
                    checkOutput({p, "_wait_cycles"}, 32'(waitCnt), 32'(v.expWait));
                end
                if (flush_rsp_ready) begin
                    if (tagQ.size() == 0) begin
                        checkOutput({p, "_unexpected_rsp"}, 32'(flush_rsp_tag), 32'(v.tag));
                    end else begin
                        exp = 3'(0);
                        checkOutput({p, "_rsp_tag"}, 32'(flush_rsp_tag), 32'(tagQ.pop_front()));
                    end
                    gotRsp = 1;
                end else begin
                    if (tagQ.size() != 0) checkOutput({p, "_stall_tag"}, 32'(flush_rsp_tag), 32'(tagQ[0]));
                    stallLeft--;
                end
            end
        end

        if (!gotRsp) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: actual no response after %0d cycles, required a response", p, k);
        end
        checkOutput({p, "_first_valid"}, 32'(firstValid), 32'(v.expFirstValid));
        if (v.expWalk >= 0) checkOutput({p, "_walk_cycles"}, 32'(walkCycles), 32'(v.expWalk));
        checkOutput({p, "_accepts_b0"}, 32'(acc[0]), 32'(v.expCmds));
        checkOutput({p, "_accepts_b1"}, 32'(acc[1]), 32'(v.expCmds));
        checkOutput({p, "_left_b0"}, 32'(cmdQ[0].size()), 0);
        checkOutput({p, "_left_b1"}, 32'(cmdQ[1].size()), 0);
        cmdQ[0].delete();
        cmdQ[1].delete();
        tagQ.delete();
    endtask

    initial begin
        int  n;
        bit  hit;

        compared   = 0;
        mismatched = 0;
        vecs[0] = '{tag:16'h005A, preReqs:0, extraReq:0, rspGap:1, b1Period:1, wbCycles:0, rspStall:0, holdNext:0, expFirstValid:2, expWalk:8,  expWait:2,  expCmds:8};
        vecs[1] = '{tag:16'h0011, preReqs:3, extraReq:0, rspGap:2, b1Period:1, wbCycles:0, rspStall:0, holdNext:0, expFirstValid:7, expWalk:8,  expWait:2,  expCmds:8};
        vecs[2] = '{tag:16'h0012, preReqs:3, extraReq:1, rspGap:2, b1Period:1, wbCycles:0, rspStall:0, holdNext:0, expFirstValid:9, expWalk:8,  expWait:2,  expCmds:8};
        vecs[3] = '{tag:16'h0033, preReqs:0, extraReq:0, rspGap:1, b1Period:3, wbCycles:0, rspStall:0, holdNext:0, expFirstValid:2, expWalk:23, expWait:2,  expCmds:8};
        vecs[4] = '{tag:16'h0044, preReqs:0, extraReq:0, rspGap:1, b1Period:1, wbCycles:10, rspStall:0, holdNext:0, expFirstValid:2, expWalk:8, expWait:12, expCmds:8};
        vecs[5] = '{tag:16'h0055, preReqs:0, extraReq:0, rspGap:1, b1Period:1, wbCycles:0, rspStall:5, holdNext:1, expFirstValid:2, expWalk:8,  expWait:2,  expCmds:8};
        vecs[6] = '{tag:16'h0066, preReqs:0, extraReq:0, rspGap:1, b1Period:1, wbCycles:0, rspStall:0, holdNext:0, expFirstValid:2, expWalk:8,  expWait:2,  expCmds:8};
        vecs[7] = '{tag:16'hBEEF, preReqs:0, extraReq:0, rspGap:1, b1Period:2, wbCycles:0, rspStall:0, holdNext:0, expFirstValid:2, expWalk:-1, expWait:2,  expCmds:8};

        reset            = 1'b1;
        flush_req_valid  = 1'b0;
        flush_req_tag    = '0;
        flush_rsp_ready  = 1'b0;
        core_req_fire    = '0;
        core_rsp_fire    = '0;
        flush_line_ready = '0;
        bank_idle        = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_req_ready", 32'(flush_req_ready), 1);

        for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i], vecs[i + 1].tag);

        // Abandon a flush mid-walk and confirm the next one restarts from (0,0).
        @(posedge clk); #1;
        flush_req_valid  = 1'b1;
        flush_req_tag    = 16'h007E;
        flush_line_ready = 2'b11;
        bank_idle        = 2'b11;
        flush_rsp_ready  = 1'b1;
        @(negedge clk);
        checkOutput("rst_seq_accept", 32'(flush_req_ready), 1);
        hit = 0;
        n   = 0;
        while (!hit && n < 20) begin
            n++;
            @(posedge clk); #1;
            flush_req_valid = 1'b0;
            @(negedge clk);
            if (flush_line_valid != 2'b00 && flush_line_set == 2'd2) hit = 1;
        end
        checkOutput("rst_seq_reached_set2", 32'(hit), 1);
        @(posedge clk); #1;
        reset            = 1'b1;
        flush_line_ready = 2'b00;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkAllZero("mid_walk_reset");
        reset            = 1'b0;
        flush_line_ready = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("after_abort_busy", 32'(busy), 0);
        checkOutput("after_abort_req_ready", 32'(flush_req_ready), 1);
        checkOutput("after_abort_rsp_valid", 32'(flush_rsp_valid), 0);

        applyStimulus(7, vecs[7], 16'h0000);

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("final_lock", 32'(core_req_lock), 0);
        checkOutput("final_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
